// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared widths, stall encodings, field indices, divider state
//                encodings and bus layouts for the EX stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    // Bus widths
    localparam int STALL_BUS_WD = 6;
    localparam int ID_TO_EX_WD  = 165;
    localparam int EX_TO_MEM_WD = 144;
    localparam int EX_TO_RF_WD  = 104;

    // Stall vector encoding and stage indices
    localparam logic STOP     = 1'b1;
    localparam logic NO_STOP  = 1'b0;
    localparam int   STALL_ID = 2;
    localparam int   STALL_EX = 3;

    // One-hot ALU operation bit indices
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    // Operand select bit indices
    localparam int SRC1_RS   = 0;
    localparam int SRC1_PC   = 1;
    localparam int SRC1_SA   = 2;
    localparam int SRC2_RT   = 0;
    localparam int SRC2_SIMM = 1;
    localparam int SRC2_8    = 2;
    localparam int SRC2_UIMM = 3;

    // Memory operation bit indices
    localparam int MEM_LW = 0;
    localparam int MEM_SW = 1;

    // hilo_op = {div, divu, mult, multu}
    localparam int HILO_MULTU = 0;
    localparam int HILO_MULT  = 1;
    localparam int HILO_DIVU  = 2;
    localparam int HILO_DIV   = 3;

    // Divider FSM encodings
    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_BUSY    = 2'd1,
        DIV_DIVZERO = 2'd2,
        DIV_DONE    = 2'd3
    } div_state_t;

    // Decoded instruction from ID (first field is the MSB end)
    typedef struct packed {
        logic [3:0]  hilo_op;
        logic [1:0]  mem_op;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_to_ex_t;

    typedef struct packed {
        logic [1:0]  mem_op;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
        logic        hi_we;
        logic [31:0] hi;
        logic        lo_we;
        logic [31:0] lo;
    } ex_to_mem_t;

    typedef struct packed {
        logic        hi_we;
        logic [31:0] hi;
        logic        lo_we;
        logic [31:0] lo;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } ex_to_rf_t;

    // Magnitude of a value that may be interpreted as two's complement
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic use_sign);
        return (use_sign && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module      : div
//  Description : Iterative radix-2 restoring divider, signed or unsigned.
//                IDLE -> BUSY (32 cycles) -> DONE -> IDLE, with DIVZERO
//                standing in for BUSY when the divisor is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module div
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;

    // Partial remainder shifted left with the next dividend bit, and trial subtract
    logic [32:0] w_shift;
    logic [33:0] w_diff;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_divisor};

    // FSM and datapath: magnitudes sampled on IDLE exit, one quotient bit per BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_divisor <= abs32(b, signed_op);
                        r_neg_q   <= signed_op & (a[31] ^ b[31]);
                        r_neg_r   <= signed_op & a[31];
                        if (b == 32'd0) begin
                            r_quo   <= '0;
                            r_state <= DIV_DIVZERO;
                        end else begin
                            r_quo   <= abs32(a, signed_op);
                            r_state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (!w_diff[33]) begin
                        r_rem <= w_diff[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DIVZERO: r_state <= DIV_DONE;
                DIV_DONE:    r_state <= DIV_IDLE;
                default:     r_state <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == DIV_BUSY) || (r_state == DIV_DIVZERO);
    assign done      = (r_state == DIV_DONE);
    // Sign correction: quotient negative iff signs differ, remainder follows dividend
    assign quotient  = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign remainder = r_neg_r ? (~r_rem + 32'd1) : r_rem;

endmodule
`default_nettype wire

// File: rtl/ex.sv
`default_nettype none
// ============================================================================
//  Module      : ex
//  Description : Execute stage: ID/EX pipeline register, inline ALU, data RAM
//                request, single-cycle multiply and iterative divide.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex
    import ex_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    ex_is_load,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_to_ex_t   r_ex;
    logic        r_div_consumed;

    logic        w_load_bubble;
    logic        w_load_new;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [31:0] w_sra;
    logic [31:0] w_alu_result;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_product;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_div_start;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_div_quo;
    logic [31:0] w_div_rem;
    logic        w_hi_we;
    logic        w_lo_we;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    ex_to_mem_t  w_mem;
    ex_to_rf_t   w_rf;
    logic        w_unused;

    assign w_load_bubble = (stall[STALL_ID] == STOP) && (stall[STALL_EX] == NO_STOP);
    assign w_load_new    = (stall[STALL_ID] == NO_STOP);

    // ID/EX pipeline register: bubble, load or hold
    always_ff @(posedge clk) begin
        if (rst || w_load_bubble) begin
            r_ex <= '0;
        end else if (w_load_new) begin
            r_ex <= id_to_ex_t'(id_to_ex_bus);
        end
    end

    // Remembers that the divide currently held in EX has already completed
    always_ff @(posedge clk) begin
        if (rst || w_load_bubble || w_load_new) begin
            r_div_consumed <= 1'b0;
        end else if (w_div_done) begin
            r_div_consumed <= 1'b1;
        end
    end

    // One-hot operand selection
    always_comb begin
        w_src1 = ({32{r_ex.sel_alu_src1[SRC1_RS]}} & r_ex.rdata1)
               | ({32{r_ex.sel_alu_src1[SRC1_PC]}} & r_ex.pc)
               | ({32{r_ex.sel_alu_src1[SRC1_SA]}} & {27'd0, r_ex.inst[10:6]});
        w_src2 = ({32{r_ex.sel_alu_src2[SRC2_RT]}}   & r_ex.rdata2)
               | ({32{r_ex.sel_alu_src2[SRC2_SIMM]}} & {{16{r_ex.inst[15]}}, r_ex.inst[15:0]})
               | ({32{r_ex.sel_alu_src2[SRC2_8]}}    & 32'd8)
               | ({32{r_ex.sel_alu_src2[SRC2_UIMM]}} & {16'd0, r_ex.inst[15:0]});
    end

    // Kept separate so the arithmetic shift is evaluated in a signed context
    assign w_sra = $signed(w_src2) >>> w_src1[4:0];

    // ALU: OR of the one-hot selected function results
    always_comb begin
        w_alu_result = ({32{r_ex.alu_op[ALU_ADD]}}  & (w_src1 + w_src2))
                     | ({32{r_ex.alu_op[ALU_SUB]}}  & (w_src1 - w_src2))
                     | ({32{r_ex.alu_op[ALU_SLT]}}  & {31'd0, $signed(w_src1) < $signed(w_src2)})
                     | ({32{r_ex.alu_op[ALU_SLTU]}} & {31'd0, w_src1 < w_src2})
                     | ({32{r_ex.alu_op[ALU_AND]}}  & (w_src1 & w_src2))
                     | ({32{r_ex.alu_op[ALU_NOR]}}  & ~(w_src1 | w_src2))
                     | ({32{r_ex.alu_op[ALU_OR]}}   & (w_src1 | w_src2))
                     | ({32{r_ex.alu_op[ALU_XOR]}}  & (w_src1 ^ w_src2))
                     | ({32{r_ex.alu_op[ALU_SLL]}}  & (w_src2 << w_src1[4:0]))
                     | ({32{r_ex.alu_op[ALU_SRL]}}  & (w_src2 >> w_src1[4:0]))
                     | ({32{r_ex.alu_op[ALU_SRA]}}  & w_sra)
                     | ({32{r_ex.alu_op[ALU_LUI]}}  & {w_src2[15:0], 16'd0});
    end

    // Multiply: operands extended to 64 bits so the low 64 bits serve both signednesses
    assign w_is_mul  = r_ex.hilo_op[HILO_MULT] | r_ex.hilo_op[HILO_MULTU];
    assign w_mul_a   = {{32{r_ex.hilo_op[HILO_MULT] & r_ex.rdata1[31]}}, r_ex.rdata1};
    assign w_mul_b   = {{32{r_ex.hilo_op[HILO_MULT] & r_ex.rdata2[31]}}, r_ex.rdata2};
    assign w_product = w_mul_a * w_mul_b;

    // Divide: start only from IDLE and only once per instruction occupying EX
    assign w_is_div    = r_ex.hilo_op[HILO_DIV] | r_ex.hilo_op[HILO_DIVU];
    assign w_div_start = w_is_div & ~w_div_busy & ~w_div_done & ~r_div_consumed;

    div u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .signed_op (r_ex.hilo_op[HILO_DIV]),
        .a         (r_ex.rdata1),
        .b         (r_ex.rdata2),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    assign stallreq_for_ex = w_div_start | w_div_busy;

    // HI/LO write selection
    always_comb begin
        w_hi_we = 1'b0;
        w_lo_we = 1'b0;
        w_hi    = '0;
        w_lo    = '0;
        if (w_is_mul) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi    = w_product[63:32];
            w_lo    = w_product[31:0];
        end else if (w_is_div && w_div_done) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi    = w_div_rem;
            w_lo    = w_div_quo;
        end
    end

    // Data RAM request issued in the EX cycle
    assign data_sram_en    = r_ex.data_ram_en;
    assign data_sram_wen   = r_ex.mem_op[MEM_SW] ? 4'b1111 : 4'b0000;
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = r_ex.rdata2;
    assign ex_is_load      = r_ex.mem_op[MEM_LW];

    // Output bus assembly
    always_comb begin
        w_mem.mem_op       = r_ex.mem_op;
        w_mem.pc           = r_ex.pc;
        w_mem.data_ram_en  = r_ex.data_ram_en;
        w_mem.data_ram_wen = r_ex.data_ram_wen;
        w_mem.sel_rf_res   = r_ex.sel_rf_res;
        w_mem.rf_we        = r_ex.rf_we;
        w_mem.rf_waddr     = r_ex.rf_waddr;
        w_mem.ex_result    = w_alu_result;
        w_mem.hi_we        = w_hi_we;
        w_mem.hi           = w_hi;
        w_mem.lo_we        = w_lo_we;
        w_mem.lo           = w_lo;
        w_rf.hi_we         = w_hi_we;
        w_rf.hi            = w_hi;
        w_rf.lo_we         = w_lo_we;
        w_rf.lo            = w_lo;
        w_rf.rf_we         = r_ex.rf_we;
        w_rf.rf_waddr      = r_ex.rf_waddr;
        w_rf.rf_wdata      = w_alu_result;
    end

    assign ex_to_mem_bus = w_mem;
    assign ex_to_rf_bus  = w_rf;

    // Stall bits of other stages and upper instruction bits are not used here
    assign w_unused = ^{stall[5:4], stall[1:0], r_ex.inst[31:16]};

endmodule
`default_nettype wire

// File: tb/tb_ex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex
//  Description : Self-checking bench for the EX stage against a behavioural
//                reference model with randomised and directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex;
    import ex_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [STALL_BUS_WD-1:0] stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus;
    logic                    ex_is_load;
    logic                    stallreq_for_ex;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;

    ex_to_mem_t mem_o;
    ex_to_rf_t  rf_o;

    int n_vec = 0;
    int n_err = 0;

    assign mem_o = ex_to_mem_bus;
    assign rf_o  = ex_to_rf_bus;

    always #5 clk = ~clk;

    ex dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .ex_is_load      (ex_is_load),
        .stallreq_for_ex (stallreq_for_ex),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ID_TO_EX_WD-1:0] rand_bus();
        logic [191:0] tmp;
        tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return tmp[ID_TO_EX_WD-1:0];
    endfunction

    // mk: 0 = lw, 1 = sw, 2 = none ; hk: 0 = mult, 1 = multu, 2 = none
    function automatic id_to_ex_t build(input int op, input int s1, input int s2, input int mk,
                                        input int hk, input logic [31:0] r1, input logic [31:0] r2,
                                        input logic [31:0] pc, input logic [31:0] inst);
        id_to_ex_t t;
        t = '0;
        t.alu_op[op]       = 1'b1;
        t.sel_alu_src1[s1] = 1'b1;
        t.sel_alu_src2[s2] = 1'b1;
        t.rdata1 = r1;
        t.rdata2 = r2;
        t.pc     = pc;
        t.inst   = inst;
        if (mk == 0) begin
            t.mem_op[MEM_LW] = 1'b1;
            t.data_ram_en    = 1'b1;
            t.sel_rf_res     = 1'b1;
        end else if (mk == 1) begin
            t.mem_op[MEM_SW] = 1'b1;
            t.data_ram_en    = 1'b1;
            t.data_ram_wen   = 4'hF;
        end
        if (hk == 0) t.hilo_op[HILO_MULT] = 1'b1;
        if (hk == 1) t.hilo_op[HILO_MULTU] = 1'b1;
        t.rf_we    = (mk != 1) && (hk == 2);
        t.rf_waddr = inst[20:16];
        return t;
    endfunction

    function automatic logic [31:0] ref_alu(input int op, input int s1, input int s2, input id_to_ex_t t);
        logic [31:0]        a;
        logic [31:0]        b;
        logic signed [31:0] sb;
        case (s1)
            SRC1_RS: a = t.rdata1;
            SRC1_PC: a = t.pc;
            default: a = 32'(t.inst[10:6]);
        endcase
        case (s2)
            SRC2_RT:   b = t.rdata2;
            SRC2_SIMM: b = 32'($signed(t.inst[15:0]));
            SRC2_8:    b = 32'd8;
            default:   b = 32'(t.inst[15:0]);
        endcase
        sb = b;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_AND:  return a & b;
            ALU_NOR:  return ~(a | b);
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return b << a[4:0];
            ALU_SRL:  return b >> a[4:0];
            ALU_SRA:  return sb >>> a[4:0];
            default:  return b * 32'd65536;
        endcase
    endfunction

    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint la, lb, lq, lr;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la % lb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic apply_vec(input id_to_ex_t t, input int op, input int s1, input int s2,
                             input int mk, input int hk);
        logic [31:0] alu;
        logic [63:0] prod;
        longint      sp;
        ex_to_mem_t  em;
        ex_to_rf_t   er;
        alu  = ref_alu(op, s1, s2, t);
        prod = '0;
        if (hk == 0) begin
            sp   = longint'($signed(t.rdata1)) * longint'($signed(t.rdata2));
            prod = sp;
        end else if (hk == 1) begin
            prod = {32'd0, t.rdata1} * {32'd0, t.rdata2};
        end
        em              = '0;
        em.mem_op       = t.mem_op;
        em.pc           = t.pc;
        em.data_ram_en  = t.data_ram_en;
        em.data_ram_wen = t.data_ram_wen;
        em.sel_rf_res   = t.sel_rf_res;
        em.rf_we        = t.rf_we;
        em.rf_waddr     = t.rf_waddr;
        em.ex_result    = alu;
        em.hi_we        = (hk < 2);
        em.hi           = prod[63:32];
        em.lo_we        = (hk < 2);
        em.lo           = prod[31:0];
        er.hi_we        = em.hi_we;
        er.hi           = em.hi;
        er.lo_we        = em.lo_we;
        er.lo           = em.lo;
        er.rf_we        = t.rf_we;
        er.rf_waddr     = t.rf_waddr;
        er.rf_wdata     = alu;
        @(negedge clk);
        id_to_ex_bus = t;
        stall        = '0;
        @(posedge clk);
        #1;
        check_val("mem_bus", ex_to_mem_bus, em);
        check_val("rf_bus", ex_to_rf_bus, er);
        check_val("sram_en", data_sram_en, (mk < 2));
        check_val("sram_wen", data_sram_wen, (mk == 1) ? 4'hF : 4'h0);
        check_val("sram_addr", data_sram_addr, alu);
        check_val("sram_wdata", data_sram_wdata, t.rdata2);
        check_val("is_load", ex_is_load, (mk == 0));
        check_val("stallreq", stallreq_for_ex, 1'b0);
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic hold_done);
        id_to_ex_t   t;
        logic [31:0] q, r;
        int          cyc;
        int          early;
        ref_div(sgn, a, b, q, r);
        t = '0;
        t.hilo_op[sgn ? HILO_DIV : HILO_DIVU] = 1'b1;
        t.rdata1 = a;
        t.rdata2 = b;
        t.pc     = $urandom;
        @(negedge clk);
        id_to_ex_bus = t;
        stall        = '0;
        @(posedge clk);
        #1;
        cyc   = 0;
        early = 0;
        while (stallreq_for_ex && cyc < 100) begin
            if (rf_o.hi_we || rf_o.lo_we || mem_o.hi_we) early++;
            stall        = 6'b001111;
            id_to_ex_bus = rand_bus();
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val("div_stall_cycles", cyc, (b == 32'd0) ? 2 : 33);
        check_val("div_we_early", early, 0);
        check_val("div_we", {rf_o.hi_we, rf_o.lo_we, mem_o.hi_we, mem_o.lo_we}, 4'hF);
        check_val("div_hi", rf_o.hi, r);
        check_val("div_lo", rf_o.lo, q);
        check_val("div_mem_hilo", {mem_o.hi, mem_o.lo}, {r, q});
        if (hold_done) begin
            stall = 6'b001100;
            @(posedge clk);
            #1;
            check_val("div_no_retrigger", {stallreq_for_ex, rf_o.hi_we}, 2'b00);
        end
        @(negedge clk);
        stall        = '0;
        id_to_ex_bus = '0;
        @(posedge clk);
        #1;
        check_val("div_after", {stallreq_for_ex, rf_o.hi_we, rf_o.lo_we}, 3'b000);
    endtask

    initial begin
        id_to_ex_t t;
        int        op, s1, s2, mk, hk, writes;
        logic [31:0] a, b;

        // Reset with garbage on the input bus
        rst          = 1'b1;
        stall        = '0;
        id_to_ex_bus = rand_bus();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mem_bus", ex_to_mem_bus, '0);
        check_val("rst_rf_bus", ex_to_rf_bus, '0);
        check_val("rst_stallreq", stallreq_for_ex, 1'b0);
        check_val("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, '0);
        check_val("rst_is_load", ex_is_load, 1'b0);
        @(negedge clk);
        rst          = 1'b0;
        id_to_ex_bus = '0;

        // addu wrap-around
        t = build(ALU_ADD, SRC1_RS, SRC2_RT, 2, 2, 32'hFFFFFFFF, 32'd1, 32'hBFC00000, 32'h00221821);
        apply_vec(t, ALU_ADD, SRC1_RS, SRC2_RT, 2, 2);
        check_val("addu_wdata", rf_o.rf_wdata, 32'h0);
        check_val("addu_we", rf_o.rf_we, 1'b1);

        // sw with negative offset
        t = build(ALU_ADD, SRC1_RS, SRC2_SIMM, 1, 2, 32'h1000, 32'hDEADBEEF, 32'hBFC00004, 32'hAC02FFFC);
        apply_vec(t, ALU_ADD, SRC1_RS, SRC2_SIMM, 1, 2);
        check_val("sw_addr", data_sram_addr, 32'h00000FFC);
        check_val("sw_wen", data_sram_wen, 4'b1111);
        check_val("sw_wdata", data_sram_wdata, 32'hDEADBEEF);

        // multu
        t = build(ALU_ADD, SRC1_RS, SRC2_RT, 2, 1, 32'hFFFFFFFF, 32'd2, 32'hBFC00008, 32'h00430019);
        apply_vec(t, ALU_ADD, SRC1_RS, SRC2_RT, 2, 1);
        check_val("multu_hilo", {rf_o.hi, rf_o.lo}, 64'h00000001_FFFFFFFE);

        // Hold then bubble
        t = build(ALU_ADD, SRC1_RS, SRC2_RT, 2, 2, 32'd5, 32'd7, 32'hBFC0000C, 32'h00851021);
        apply_vec(t, ALU_ADD, SRC1_RS, SRC2_RT, 2, 2);
        @(negedge clk);
        stall        = 6'b001100;
        id_to_ex_bus = rand_bus();
        @(posedge clk);
        #1;
        check_val("hold_wdata", rf_o.rf_wdata, 32'd12);
        @(negedge clk);
        stall = 6'b000100;
        @(posedge clk);
        #1;
        check_val("bubble_mem", ex_to_mem_bus, '0);
        check_val("bubble_rf", ex_to_rf_bus, '0);
        @(negedge clk);
        stall        = '0;
        id_to_ex_bus = '0;

        // Directed divides
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_div(1'b0, 32'd100, 32'd0, 1'b0);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0);

        // Reset while the divider is busy
        t = '0;
        t.hilo_op[HILO_DIVU] = 1'b1;
        t.rdata1 = 32'd1000;
        t.rdata2 = 32'd7;
        @(negedge clk);
        id_to_ex_bus = t;
        stall        = '0;
        @(posedge clk);
        #1;
        stall = 6'b001111;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_abort_stall", stallreq_for_ex, 1'b0);
        @(negedge clk);
        rst          = 1'b0;
        stall        = '0;
        id_to_ex_bus = '0;
        writes       = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rf_o.hi_we || rf_o.lo_we || mem_o.hi_we || mem_o.lo_we) writes++;
        end
        check_val("rst_abort_writes", writes, 0);

        // Randomised single-cycle instructions
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 11);
            s1 = $urandom_range(0, 2);
            s2 = $urandom_range(0, 3);
            mk = $urandom_range(0, 3);
            if (mk > 2) mk = 2;
            hk = $urandom_range(0, 4);
            if (hk > 2) hk = 2;
            t = build(op, s1, s2, mk, hk, $urandom, $urandom, $urandom, $urandom);
            apply_vec(t, op, s1, s2, mk, hk);
        end

        // Randomised divides
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 20);
                2:       b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_div(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 Parameters: none; all widths come from the shared defines file (`StallBus, `ID_TO_EX_WD, `EX_TO_MEM_WD, `EX_TO_RF_WD).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  `StallBus  pipeline stall vector; bit 2 = ID, bit 3 = EX, `Stop/`NoStop.
REQ-005 id_to_ex_bus  in  `ID_TO_EX_WD  decoded instruction from ID; existing field order, plus hilo_op[3:0] = {div, divu, mult, multu} at the MSB end.
REQ-006 ex_to_mem_bus  out  `EX_TO_MEM_WD  {mem_op, pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result, hi_we, hi, lo_we, lo}.
REQ-007 ex_to_rf_bus  out  `EX_TO_RF_WD  forwarding to ID: {hi_we, hi[31:0], lo_we, lo[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
REQ-008 ex_is_load  out  1  current EX instruction is lw; ID uses it for stallreq_for_load.
REQ-009 stallreq_for_ex  out  1  divider busy; requests a stall of stages 0..3.
REQ-010 data_sram_en / data_sram_wen[3:0] / data_sram_addr[31:0] / data_sram_wdata[31:0]  out  data RAM request.

Function
REQ-011 Pipeline register: if stall[2]=Stop and stall[3]=NoStop, the register SHALL load all-zero (bubble); else if stall[2]=NoStop it SHALL load id_to_ex_bus; otherwise it SHALL hold.
REQ-012 ALU operands: src1 = rdata1 | pc | zero-extended sa; src2 = rdata2 | sign-extended imm | 32'd8 | zero-extended imm; selected one-hot by sel_alu_src1/2.
REQ-013 The ALU SHALL implement the 12 alu_op functions combinationally (add/sub wrap mod 2^32, no overflow trap; lui = imm<<16; shifts use src1[4:0]).
REQ-014 Memory: data_sram_en = data_ram_en; data_sram_wen = 4'b1111 for sw, else 0; addr = ALU result; wdata = rdata2; issued in the same cycle as EX.
REQ-015 rf_wdata = ALU result; ex_is_load = mem_op[0] (lw).
REQ-016 mult/multu: single-cycle 64-bit product; hi = [63:32], lo = [31:0]; hi_we = lo_we = 1.
REQ-017 div/divu: iterative radix-2 divider, FSM IDLE -> BUSY (32 cycles) -> DONE (1 cycle) -> IDLE; DIVZERO replaces BUSY when the divisor is 0.
REQ-018 The FSM SHALL leave IDLE on the first cycle a div/divu is in EX; stallreq_for_ex SHALL be 1 in that cycle and throughout BUSY/DIVZERO, and 0 in DONE.
REQ-019 Total latency: result valid in the DONE cycle, 34 cycles after entry; hi = remainder, lo = quotient; hi_we = lo_we = 1 only in DONE.
REQ-020 Signed div: operate on magnitudes; quotient negative iff signs differ; remainder takes the dividend's sign; 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
REQ-021 Divide by zero: DIVZERO lasts 1 cycle, then DONE with hi = lo = 0.
REQ-022 The divider SHALL sample operands at IDLE exit and SHALL NOT re-trigger on the same instruction in DONE.
REQ-023 For non-hilo instructions, hi_we = lo_we = 0 and hi = lo = 0.

Reset
REQ-024 With rst=1 at a clock edge: pipeline register <= 0, FSM <= IDLE, divider counter/operands <= 0.
REQ-025 Consequently all outputs SHALL be 0 after reset, including stallreq_for_ex, data_sram_en, and the bus valid/we bits.
REQ-026 Reset mid-division SHALL abort it: no hi/lo write is issued afterward.

Structure
REQ-027 The FSM state encodings and the hilo_op bit indices SHALL be added to lib/defines.vh; the bus widths remain defined there.
REQ-028 The divider SHALL be one sub-module, div (clk, rst, start, signed_op, a, b, busy, done, quotient, remainder); ALU logic stays inline.

Verification
REQ-029 addu rdata1=0xFFFFFFFF, rdata2=1 -> rf_wdata = 0x00000000, rf_we = 1, no stall.
REQ-030 sw rdata1=0x1000, imm=0xFFFC, rdata2=0xDEADBEEF -> data_sram_addr = 0x0FFC, wen = 4'b1111, wdata = 0xDEADBEEF.
REQ-031 div signed 0xFFFFFFF9 (-7) / 2 -> stallreq_for_ex high for 33 cycles; in DONE lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, both we = 1.
REQ-032 divu 100 / 0 -> stallreq_for_ex high for 2 cycles; then lo = hi = 0.
REQ-033 multu 0xFFFFFFFF * 2 -> hi = 0x00000001, lo = 0xFFFFFFFE in the same cycle.
REQ-034 stall[2]=Stop, stall[3]=NoStop -> next-cycle bus fields all zero; assert rst during BUSY -> stallreq_for_ex = 0 next cycle and no hi/lo write.
